// File: rtl/tester_pkg.sv
// rtl/tester_pkg.sv - shared opcodes, FSM states and frame sizing for the tester controller
package tester_pkg;

  localparam int PAYLOAD_W = 6;

  typedef enum logic [1:0] {
    OP_DATA = 2'b00,
    OP_GET  = 2'b01,
    OP_SET  = 2'b10,
    OP_RST  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_SEND,
    S_RESET
  } state_e;

  function automatic int nbytes(input int data_w);
    return (data_w + PAYLOAD_W - 1) / PAYLOAD_W;
  endfunction

endpackage

// File: rtl/tester_ctrl_if.sv
// rtl/tester_ctrl_if.sv - button, UART, memory and status signals of the tester controller
interface tester_ctrl_if #(parameter int DATA_W = 6);
  logic [DATA_W-1:0] in_push_sw;
  logic              in_push_rst;
  logic              in_urx_vld;
  logic [7:0]        in_urx;
  logic [DATA_W-1:0] in_mem;
  logic              in_mem_w_rd;
  logic              in_utx_rdy;
  logic [DATA_W-1:0] out_mem;
  logic              out_mem_w_en;
  logic              out_utx_vld;
  logic [7:0]        out_utx_data;
  logic              out_rst;
  logic              out_err;
  logic              out_busy;

  modport slave (
    input  in_push_sw, in_push_rst, in_urx_vld, in_urx, in_mem, in_mem_w_rd, in_utx_rdy,
    output out_mem, out_mem_w_en, out_utx_vld, out_utx_data, out_rst, out_err, out_busy
  );

  modport master (
    output in_push_sw, in_push_rst, in_urx_vld, in_urx, in_mem, in_mem_w_rd, in_utx_rdy,
    input  out_mem, out_mem_w_en, out_utx_vld, out_utx_data, out_rst, out_err, out_busy
  );
endinterface

// File: rtl/tester_tx_serializer.sv
// rtl/tester_tx_serializer.sv - splits a state snapshot into 6-bit echo frames over valid/ready
module tester_tx_serializer
  import tester_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int NBYTES = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] snapshot,
  input  logic              utx_rdy,
  output logic              utx_vld,
  output logic [7:0]        utx_data,
  output logic              done
);

  localparam int PAD_W = NBYTES * PAYLOAD_W;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [PAD_W-1:0] pad;
  logic [PAD_W-1:0] rest;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign pad  = PAD_W'(snapshot);
  assign last = (idx == IDX_W'(NBYTES - 1));
  // Combinational so the controller can leave SEND on the same edge as the final accept.
  assign done = utx_vld && utx_rdy && last;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      utx_vld  <= 1'b0;
      utx_data <= '0;
      rest     <= '0;
      idx      <= '0;
    end else if (start) begin
      utx_vld  <= 1'b1;
      utx_data <= {OP_GET, pad[PAYLOAD_W-1:0]};
      rest     <= pad >> PAYLOAD_W;
      idx      <= '0;
    end else if (utx_vld && utx_rdy) begin
      if (last) begin
        utx_vld  <= 1'b0;
        utx_data <= '0;
      end else begin
        utx_data <= {OP_GET, rest[PAYLOAD_W-1:0]};
        rest     <= rest >> PAYLOAD_W;
        idx      <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tester_ctrl.sv
// rtl/tester_ctrl.sv - arbitrates buttons against UART commands, writes test state and echoes it back
module tester_ctrl
  import tester_pkg::*;
#(
  parameter int DATA_W      = 6,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int RST_CYC     = 4
) (
  input logic in_clk,
  input logic in_rst,
  tester_ctrl_if.slave bus
);

  localparam int NBYTES = nbytes(DATA_W);
  localparam int PAD_W  = NBYTES * PAYLOAD_W;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int RC_W   = $clog2(RST_CYC + 1);
  localparam int CNT_W  = $clog2(NBYTES) + 1;

  state_e                 state;
  logic [DATA_W-1:0]      snapshot;
  logic [PAD_W-1:0]       buffer;
  logic [PAD_W-1:0]       buf_merged;
  logic [CNT_W-1:0]       byte_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [RC_W-1:0]        rst_cnt;
  logic                   w_en_q, rst_q, err_q, busy_q;
  opcode_e                op;
  logic [PAYLOAD_W-1:0]   payload;
  logic                   byte_get, byte_set, byte_rst, byte_data;
  logic                   sw_hit, ser_start, ser_done;
  logic [DATA_W-1:0]      ser_snap;

  assign op        = opcode_e'(bus.in_urx[7:6]);
  assign payload   = bus.in_urx[PAYLOAD_W-1:0];
  assign byte_get  = bus.in_urx_vld && (op == OP_GET);
  assign byte_set  = bus.in_urx_vld && (op == OP_SET);
  assign byte_rst  = bus.in_urx_vld && (op == OP_RST);
  assign byte_data = bus.in_urx_vld && (op == OP_DATA);
  assign sw_hit    = (bus.in_push_sw != '0);

  // Upper chunks of buffer are cleared by SET, so OR-ing the new chunk in is enough.
  assign buf_merged = buffer | (PAD_W'(payload) << (byte_cnt * PAYLOAD_W));

  // The serializer loads on the same edge the FSM enters SEND, so the first byte is valid at t+1.
  assign ser_start = (state == S_IDLE && !sw_hit && byte_get) || (state == S_WRITE && bus.in_mem_w_rd);
  assign ser_snap  = (state == S_WRITE) ? snapshot : bus.in_mem;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= S_IDLE;
      snapshot <= '0;
      buffer   <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      rst_cnt  <= '0;
      w_en_q   <= 1'b0;
      rst_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sw_hit) begin
            snapshot <= bus.in_mem ^ bus.in_push_sw;
            w_en_q   <= 1'b1;
            busy_q   <= 1'b1;
            state    <= S_WRITE;
          end else if (byte_get) begin
            busy_q <= 1'b1;
            state  <= S_SEND;
          end else if (byte_set) begin
            buffer   <= PAD_W'(payload);
            byte_cnt <= CNT_W'(1);
            tmo_cnt  <= '0;
            busy_q   <= 1'b1;
            if (NBYTES == 1) begin
              snapshot <= DATA_W'(payload);
              w_en_q   <= 1'b1;
              state    <= S_WRITE;
            end else begin
              state <= S_COLLECT;
            end
          end else if (byte_rst || bus.in_push_rst) begin
            rst_q   <= 1'b1;
            rst_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= S_RESET;
          end else if (byte_data) begin
            err_q <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (bus.in_urx_vld) begin
            if (op != OP_DATA) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              buffer   <= buf_merged;
              tmo_cnt  <= '0;
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                snapshot <= DATA_W'(buf_merged);
                w_en_q   <= 1'b1;
                state    <= S_WRITE;
              end
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.in_mem_w_rd) begin
            w_en_q <= 1'b0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (ser_done) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_RESET: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            rst_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  tester_tx_serializer #(
    .DATA_W (DATA_W),
    .NBYTES (NBYTES)
  ) u_ser (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .start    (ser_start),
    .snapshot (ser_snap),
    .utx_rdy  (bus.in_utx_rdy),
    .utx_vld  (bus.out_utx_vld),
    .utx_data (bus.out_utx_data),
    .done     (ser_done)
  );

  assign bus.out_mem      = snapshot;
  assign bus.out_mem_w_en = w_en_q;
  assign bus.out_rst      = rst_q;
  assign bus.out_err      = err_q;
  assign bus.out_busy     = busy_q;

endmodule

// File: tb/tb_tester_ctrl.sv
// tb/tb_tester_ctrl.sv - self-checking bench for tester_ctrl at DATA_W=6 and DATA_W=12
module tb_tester_ctrl;

  logic in_clk = 1'b0;
  logic in_rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 in_clk = ~in_clk;

  tester_ctrl_if #(.DATA_W(6))  bus6 ();
  tester_ctrl_if #(.DATA_W(12)) bus12 ();

  tester_ctrl #(.DATA_W(6), .TIMEOUT_CYC(100), .RST_CYC(4)) u6 (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus6));
  tester_ctrl #(.DATA_W(12), .TIMEOUT_CYC(100), .RST_CYC(4)) u12 (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus12));

  logic [7:0]  got_tx[$];
  logic [11:0] got_wr[$];
  logic [7:0]  exp_tx[$];
  logic [11:0] exp_wr[$];
  int          rst_hi = 0;
  int          err_hi = 0;
  bit          auto_resp = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic drive_idle();
    bus6.in_push_sw = '0;  bus6.in_push_rst = 1'b0;  bus6.in_urx_vld = 1'b0;  bus6.in_urx = '0;
    bus6.in_mem = '0;      bus6.in_mem_w_rd = 1'b0;  bus6.in_utx_rdy = 1'b0;
    bus12.in_push_sw = '0; bus12.in_push_rst = 1'b0; bus12.in_urx_vld = 1'b0; bus12.in_urx = '0;
    bus12.in_mem = '0;     bus12.in_mem_w_rd = 1'b0; bus12.in_utx_rdy = 1'b0;
  endtask

  // One clock of the 12-bit environment: optional random responders, handshake capture, memory update.
  task automatic cycle();
    logic        wr_hit;
    logic [11:0] wr_val;
    if (auto_resp) begin
      bus12.in_utx_rdy  = 1'($urandom_range(0, 1));
      bus12.in_mem_w_rd = 1'($urandom_range(0, 1));
    end
    wr_hit = bus12.out_mem_w_en && bus12.in_mem_w_rd;
    wr_val = bus12.out_mem;
    if (bus12.out_utx_vld && bus12.in_utx_rdy) got_tx.push_back(bus12.out_utx_data);
    if (wr_hit) got_wr.push_back(wr_val);
    rst_hi += int'(bus12.out_rst);
    err_hi += int'(bus12.out_err);
    @(negedge in_clk);
    if (wr_hit) bus12.in_mem = wr_val;
  endtask

  task automatic push_echo(input logic [11:0] v);
    for (int k = 0; k < 2; k++) exp_tx.push_back(8'h40 | 8'((v >> (6 * k)) & 12'h03F));
  endtask

  task automatic test_reset();
    drive_idle();
    in_rst = 1'b0;
    repeat (3) @(negedge in_clk);
    n_checks++;
    if ({bus12.out_mem_w_en, bus12.out_utx_vld, bus12.out_rst, bus12.out_err, bus12.out_busy} !== 5'b0 ||
        bus12.out_mem !== 12'h0 || bus12.out_utx_data !== 8'h0) begin
      n_fail++;
      $display("FAIL reset12: ctl=%b mem=%h data=%h, required all zero",
               {bus12.out_mem_w_en, bus12.out_utx_vld, bus12.out_rst, bus12.out_err, bus12.out_busy},
               bus12.out_mem, bus12.out_utx_data);
    end
    n_checks++;
    if ({bus6.out_mem_w_en, bus6.out_utx_vld, bus6.out_rst, bus6.out_err, bus6.out_busy} !== 5'b0 ||
        bus6.out_mem !== 6'h0 || bus6.out_utx_data !== 8'h0) begin
      n_fail++;
      $display("FAIL reset6: ctl=%b mem=%h data=%h, required all zero",
               {bus6.out_mem_w_en, bus6.out_utx_vld, bus6.out_rst, bus6.out_err, bus6.out_busy},
               bus6.out_mem, bus6.out_utx_data);
    end
    in_rst = 1'b1;
    repeat (2) @(negedge in_clk);
    n_checks++;
    if (bus12.out_busy !== 1'b0 || bus6.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: busy12=%b busy6=%b, required 0 0", bus12.out_busy, bus6.out_busy);
    end
  endtask

  task automatic test_switch_w6();
    int hi;
    bus6.in_mem = 6'h21;
    bus6.in_push_sw = 6'b000100;
    @(negedge in_clk);
    bus6.in_push_sw = '0;
    n_checks++;
    if (bus6.out_mem_w_en !== 1'b1 || bus6.out_mem !== 6'h25) begin
      n_fail++;
      $display("FAIL sw6_write: w_en=%b mem=%h, required 1 25", bus6.out_mem_w_en, bus6.out_mem);
    end
    hi = 0;
    for (int i = 0; i < 10 && bus6.out_mem_w_en; i++) begin
      hi++;
      if (hi == 3) bus6.in_mem_w_rd = 1'b1;
      @(negedge in_clk);
      bus6.in_mem_w_rd = 1'b0;
    end
    bus6.in_mem = 6'h25;
    n_checks++;
    if (hi != 3) begin
      n_fail++;
      $display("FAIL sw6_wen_len: w_en high %0d cycles, required 3", hi);
    end
    n_checks++;
    if (bus6.out_utx_vld !== 1'b1 || bus6.out_utx_data !== 8'h65) begin
      n_fail++;
      $display("FAIL sw6_echo: vld=%b data=%h, required 1 65", bus6.out_utx_vld, bus6.out_utx_data);
    end
    bus6.in_utx_rdy = 1'b1;
    @(negedge in_clk);
    bus6.in_utx_rdy = 1'b0;
    n_checks++;
    if (bus6.out_utx_vld !== 1'b0 || bus6.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sw6_done: vld=%b busy=%b, required 0 0", bus6.out_utx_vld, bus6.out_busy);
    end
  endtask

  task automatic test_set_multi();
    bit stable;
    bus12.in_urx = 8'h8A; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx = 8'h15;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    n_checks++;
    if (bus12.out_mem_w_en !== 1'b1 || bus12.out_mem !== 12'h54A) begin
      n_fail++;
      $display("FAIL set_write: w_en=%b mem=%h, required 1 54a", bus12.out_mem_w_en, bus12.out_mem);
    end
    bus12.in_mem_w_rd = 1'b1;
    @(negedge in_clk);
    bus12.in_mem_w_rd = 1'b0;
    bus12.in_mem = 12'h54A;
    n_checks++;
    if (bus12.out_mem_w_en !== 1'b0 || bus12.out_utx_vld !== 1'b1 || bus12.out_utx_data !== 8'h4A) begin
      n_fail++;
      $display("FAIL set_echo0: w_en=%b vld=%b data=%h, required 0 1 4a",
               bus12.out_mem_w_en, bus12.out_utx_vld, bus12.out_utx_data);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      if (bus12.out_utx_vld !== 1'b1 || bus12.out_utx_data !== 8'h4A) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL set_hold: vld=%b data=%h after stall, required 1 4a", bus12.out_utx_vld, bus12.out_utx_data);
    end
    bus12.in_utx_rdy = 1'b1;
    @(negedge in_clk);
    n_checks++;
    if (bus12.out_utx_vld !== 1'b1 || bus12.out_utx_data !== 8'h55) begin
      n_fail++;
      $display("FAIL set_echo1: vld=%b data=%h, required 1 55", bus12.out_utx_vld, bus12.out_utx_data);
    end
    @(negedge in_clk);
    bus12.in_utx_rdy = 1'b0;
    n_checks++;
    if (bus12.out_utx_vld !== 1'b0 || bus12.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL set_done: vld=%b busy=%b, required 0 0", bus12.out_utx_vld, bus12.out_busy);
    end
  endtask

  task automatic test_timeout();
    int first_err, err_cycles;
    bit saw_wen;
    first_err = 0; err_cycles = 0; saw_wen = 1'b0;
    bus12.in_urx = 8'h81; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge in_clk);
      if (bus12.out_err && first_err == 0) first_err = k;
      if (bus12.out_err) err_cycles++;
      if (bus12.out_mem_w_en) saw_wen = 1'b1;
    end
    n_checks++;
    if (first_err != 100) begin
      n_fail++;
      $display("FAIL timeout_cycle: err at cycle %0d, required 100", first_err);
    end
    n_checks++;
    if (err_cycles != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: err high %0d cycles, required 1", err_cycles);
    end
    n_checks++;
    if (bus12.out_busy !== 1'b0 || saw_wen) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b wrote=%b, required 0 0", bus12.out_busy, saw_wen);
    end
  endtask

  task automatic test_bad_byte();
    bit noise;
    bus12.in_urx = 8'h81; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx = 8'h40;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    n_checks++;
    if (bus12.out_err !== 1'b1 || bus12.out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_byte_err: err=%b busy=%b, required 1 0", bus12.out_err, bus12.out_busy);
    end
    noise = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge in_clk);
      if (bus12.out_mem_w_en || bus12.out_utx_vld || bus12.out_err || bus12.out_busy) noise = 1'b1;
    end
    n_checks++;
    if (noise) begin
      n_fail++;
      $display("FAIL bad_byte_quiet: activity after error=%b, required 0", noise);
    end
  endtask

  task automatic test_rst_and_priority();
    int hi;
    logic first;
    logic [11:0] m;
    bus12.in_urx = 8'hC0; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    first = bus12.out_rst;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus12.out_rst) hi++;
      @(negedge in_clk);
    end
    n_checks++;
    if (hi != 4 || first !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pulse: out_rst high %0d cycles first=%b, required 4 1", hi, first);
    end
    m = 12'h3C5;
    bus12.in_mem = m;
    bus12.in_push_sw = 12'h001; bus12.in_urx = 8'h9F; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_push_sw = '0; bus12.in_urx_vld = 1'b0;
    n_checks++;
    if (bus12.out_mem_w_en !== 1'b1 || bus12.out_mem !== (m ^ 12'h001)) begin
      n_fail++;
      $display("FAIL prio_write: w_en=%b mem=%h, required 1 %h", bus12.out_mem_w_en, bus12.out_mem, m ^ 12'h001);
    end
    bus12.in_mem_w_rd = 1'b1;
    @(negedge in_clk);
    bus12.in_mem_w_rd = 1'b0;
    bus12.in_mem = m ^ 12'h001;
    bus12.in_utx_rdy = 1'b1;
    for (int i = 0; i < 20 && bus12.out_busy; i++) @(negedge in_clk);
    bus12.in_utx_rdy = 1'b0;
    // A DATA byte must now hit IDLE (error pulse), proving the simultaneous SET was dropped.
    bus12.in_urx = 8'h15; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    n_checks++;
    if (bus12.out_err !== 1'b1 || bus12.out_busy !== 1'b0 || bus12.out_mem_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_dropped: err=%b busy=%b w_en=%b, required 1 0 0",
               bus12.out_err, bus12.out_busy, bus12.out_mem_w_en);
    end
    @(negedge in_clk);
  endtask

  task automatic test_rst_mid_send();
    logic [11:0] m;
    logic [7:0]  rx[$];
    m = 12'hA5C;
    bus12.in_mem = m;
    bus12.in_urx = 8'h40; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    bus12.in_utx_rdy = 1'b1;
    @(negedge in_clk);
    bus12.in_utx_rdy = 1'b0;
    n_checks++;
    if (bus12.out_utx_vld !== 1'b1 || bus12.out_utx_data !== 8'h69) begin
      n_fail++;
      $display("FAIL midsend_byte1: vld=%b data=%h, required 1 69", bus12.out_utx_vld, bus12.out_utx_data);
    end
    #2 in_rst = 1'b0;
    #1;
    n_checks++;
    if (bus12.out_utx_vld !== 1'b0 || bus12.out_busy !== 1'b0 || bus12.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midsend_abort: vld=%b busy=%b err=%b, required 0 0 0",
               bus12.out_utx_vld, bus12.out_busy, bus12.out_err);
    end
    @(negedge in_clk);
    in_rst = 1'b1;
    @(negedge in_clk);
    bus12.in_urx = 8'h40; bus12.in_urx_vld = 1'b1;
    @(negedge in_clk);
    bus12.in_urx_vld = 1'b0;
    bus12.in_utx_rdy = 1'b1;
    for (int i = 0; i < 10 && bus12.out_busy; i++) begin
      if (bus12.out_utx_vld) rx.push_back(bus12.out_utx_data);
      @(negedge in_clk);
    end
    bus12.in_utx_rdy = 1'b0;
    n_checks++;
    if (rx.size() != 2 || rx[0] !== 8'h5C || rx[1] !== 8'h69) begin
      n_fail++;
      $display("FAIL midsend_get_after: %0d bytes first=%h, required 2 bytes 5c 69",
               rx.size(), (rx.size() > 0) ? rx[0] : 8'h00);
    end
  endtask

  task automatic test_random_cmds();
    logic [11:0] model_mem, v, sw;
    int kind, n, exp_rst, rst0, err0, gap;
    auto_resp = 1'b1;
    model_mem = 12'($urandom);
    bus12.in_mem = model_mem;
    @(negedge in_clk);
    for (int c = 0; c < 40; c++) begin
      got_tx.delete(); got_wr.delete(); exp_tx.delete(); exp_wr.delete();
      rst0 = rst_hi; err0 = err_hi; exp_rst = 0;
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          sw = 12'($urandom_range(1, 4095));
          v = model_mem ^ sw;
          exp_wr.push_back(v); push_echo(v); model_mem = v;
          bus12.in_push_sw = sw; cycle(); bus12.in_push_sw = '0;
        end
        1: begin
          push_echo(model_mem);
          bus12.in_urx = {2'b01, 6'($urandom_range(0, 63))}; bus12.in_urx_vld = 1'b1;
          cycle(); bus12.in_urx_vld = 1'b0;
        end
        2: begin
          v = 12'($urandom);
          exp_wr.push_back(v); push_echo(v); model_mem = v;
          bus12.in_urx = {2'b10, v[5:0]}; bus12.in_urx_vld = 1'b1;
          cycle(); bus12.in_urx_vld = 1'b0;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) cycle();
          bus12.in_urx = {2'b00, v[11:6]}; bus12.in_urx_vld = 1'b1;
          cycle(); bus12.in_urx_vld = 1'b0;
        end
        3: begin
          exp_rst = 4;
          bus12.in_urx = {2'b11, 6'($urandom_range(0, 63))}; bus12.in_urx_vld = 1'b1;
          cycle(); bus12.in_urx_vld = 1'b0;
        end
        default: begin
          exp_rst = 4;
          bus12.in_push_rst = 1'b1; cycle(); bus12.in_push_rst = 1'b0;
        end
      endcase
      n = 0;
      while (bus12.out_busy && n < 400) begin
        cycle();
        n++;
      end
      n_checks++;
      if (n >= 400) begin
        n_fail++;
        $display("FAIL rand_drain: cmd %0d kind %0d still busy after %0d cycles, required idle", c, kind, n);
      end
      n_checks++;
      if (got_wr.size() != exp_wr.size()) begin
        n_fail++;
        $display("FAIL rand_wr_count: cmd %0d kind %0d got %0d writes, required %0d", c, kind, got_wr.size(), exp_wr.size());
      end else begin
        foreach (exp_wr[i]) begin
          n_checks++;
          if (got_wr[i] !== exp_wr[i]) begin
            n_fail++;
            $display("FAIL rand_wr: cmd %0d wrote %h, required %h", c, got_wr[i], exp_wr[i]);
          end
        end
      end
      n_checks++;
      if (got_tx.size() != exp_tx.size()) begin
        n_fail++;
        $display("FAIL rand_tx_count: cmd %0d kind %0d got %0d bytes, required %0d", c, kind, got_tx.size(), exp_tx.size());
      end else begin
        foreach (exp_tx[i]) begin
          n_checks++;
          if (got_tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL rand_tx: cmd %0d byte %0d got %h, required %h", c, i, got_tx[i], exp_tx[i]);
          end
        end
      end
      n_checks++;
      if (rst_hi - rst0 != exp_rst || err_hi - err0 != 0) begin
        n_fail++;
        $display("FAIL rand_rst_err: cmd %0d rst cycles %0d err %0d, required %0d 0", c, rst_hi - rst0, err_hi - err0, exp_rst);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cycle();
    end
    auto_resp = 1'b0;
    bus12.in_utx_rdy = 1'b0;
    bus12.in_mem_w_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch_w6();
    test_set_multi();
    test_timeout();
    test_bad_byte();
    test_rst_and_priority();
    test_rst_mid_send();
    test_random_cmds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tester_ctrl.md
# tester_ctrl

Parametrised command/control FSM for the FPGA tester: arbitrates front-panel switch and reset buttons against UART command bytes, updates the DATA_W-bit test-state memory, and echoes state back over UART as one or more 6-bit-payload frames. It sits between the debouncers and uart_rx on one side and the state memory and uart_tx on the other. Successor to the fixed 6-bit controller, adding:
- per-bit switch inputs
- multi-byte SET/GET
- byte-valid and tx-ready handshakes
- inter-byte timeout
- error reporting

## Interface
- DATA_W, 6, state width (1..24); NBYTES = ceil(DATA_W/6)
- TIMEOUT_CYC, 1_000_000, max idle cycles between bytes of one SET frame
- RST_CYC, 4, out_rst pulse length in cycles (≥1)

Ports:
- in_clk  in  1  system clock
- in_rst  in  1  asynchronous, active-low reset
- in_push_sw  in  DATA_W  debounced one-cycle pulses; bit i toggles channel i
- in_push_rst  in  1  debounced one-cycle reset-button pulse
- in_urx_vld  in  1  one-cycle strobe: in_urx holds a received byte
- in_urx  in  8  received byte: [7:6] opcode, [5:0] payload
- in_mem  in  DATA_W  current stored state
- in_mem_w_rd  in  1  memory write complete
- in_utx_rdy  in  1  uart_tx accepts a byte
- out_mem  out  DATA_W  write data
- out_mem_w_en  out  1  write request, held until in_mem_w_rd
- out_utx_vld  out  1  byte valid to uart_tx
- out_utx_data  out  8  byte to uart_tx
- out_rst  out  1  tester reset request
- out_err  out  1  one-cycle protocol-error pulse
- out_busy  out  1  state != IDLE

## Operation
States: IDLE, COLLECT, WRITE, SEND, RESET.

Opcodes:
- 00 DATA (continuation)
- 01 GET
- 10 SET
- 11 RST

IDLE, priority order:
1. in_push_sw != 0: snapshot ← in_mem ^ in_push_sw → WRITE.
2. GET byte: snapshot ← in_mem → SEND.
3. SET byte: buffer[5:0] ← payload, byte count = 1; go to WRITE if NBYTES = 1, otherwise COLLECT.
4. RST byte, or in_push_rst → RESET.
5. DATA byte in IDLE: ignored, out_err pulse.

A UART byte that coincides with a switch pulse is dropped silently.

COLLECT:
- Each DATA byte fills buffer chunk k (LSB chunk first) and clears the timeout counter.
- After chunk NBYTES-1: snapshot ← buffer truncated to DATA_W → WRITE.
- A non-DATA byte: out_err, → IDLE. The byte is not reinterpreted.
- Counter reaching TIMEOUT_CYC: out_err, → IDLE.
- Buttons are ignored.

WRITE:
- out_mem = snapshot, out_mem_w_en = 1.
- When in_mem_w_rd = 1: → SEND, echoing snapshot.

SEND:
- Byte k = {2'b01, snapshot[6k+5:6k]}, zero-padded above DATA_W, k = 0..NBYTES-1.
- A byte transfers when out_utx_vld && in_utx_rdy.
- After the last byte → IDLE.
- Inputs are ignored.

RESET: out_rst = 1 for exactly RST_CYC cycles, then → IDLE.

## Timing
- All outputs registered. Reset values: state IDLE; every output 0; snapshot, buffer and counters 0.
- Trigger sampled at edge t → out_mem_w_en / out_utx_vld / out_rst high from t+1.
- out_mem_w_en falls the cycle after in_mem_w_rd is sampled high. in_mem_w_rd may be high in the first WRITE cycle, giving a one-cycle request.
- out_utx_vld stays high with out_utx_data stable until accepted. The next byte is presented the cycle after acceptance, with no gap.
- SEND → IDLE the cycle after the last accept; a new command is accepted that cycle.
- in_rst low mid-operation: immediately abandon the frame; outputs 0 asynchronously; no out_err.
- Timeout fires when TIMEOUT_CYC cycles elapse with no byte; out_err asserts for one cycle on transition.

## Structure
- Package tester_pkg holds:
  - opcode_e (OP_DATA, OP_GET, OP_SET, OP_RST)
  - state_e
  - function nbytes(DATA_W)
  - localparam PAYLOAD_W = 6
- Sub-module tester_tx_serializer (DATA_W, NBYTES) takes snapshot and a start strobe, runs the valid/ready byte sequence, and pulses done. The FSM waits on done.
- Timeout counter width is $clog2(TIMEOUT_CYC+1).

## Test plan
- DATA_W=6: in_push_sw=6'b000100 with in_mem=6'h21, in_mem_w_rd after 3 cycles → out_mem=6'h25, w_en high 3 cycles; then a single byte 8'h65 is sent.
- DATA_W=12: SET 8'h8A, DATA 8'h15 → out_mem=12'h54A; echo 8'h4A then 8'h55; in_utx_rdy low 5 cycles holds the first byte stable.
- DATA_W=12: SET 8'h81, then no byte for TIMEOUT_CYC=100 cycles → out_err pulse at cycle 100, IDLE, no write.
- DATA_W=12: SET 8'h81 followed by GET 8'h40 → out_err, IDLE, no write, no send.
- RST byte 8'hC0 → out_rst high exactly RST_CYC=4 cycles. in_push_sw and an SET byte in the same cycle → switch path wins.
- in_rst low during SEND byte 1 of 2 → out_utx_vld drops immediately; after release, out_busy=0 and a GET is serviced normally.
